// File: rtl/sigmoid_lut_loader.sv
// sigmoid_lut_loader: write-side loader for the activation LUT.
// It takes a valid/ready word stream in LUT address order and turns it into
// LUT write strobes. Address 0 holds the most negative input, -2**(inWidth-1).
// Optional feature: define LUT_CHECKSUM_EN to add a running checksum output.
// The checksum is the unsigned sum of the accepted words.
module sigmoid_lut_loader #(
   parameter int inWidth   = 10,
   parameter int dataWidth = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   input  logic [dataWidth-1:0] s_data,
   input  logic                 s_valid,
   output logic                 s_ready,
   output logic                 lut_wr_en,
   output logic [inWidth-1:0]   lut_wr_addr,
   output logic [dataWidth-1:0] lut_wr_data,
   output logic                 busy,
   output logic                 done
`ifdef LUT_CHECKSUM_EN
   ,
   output logic [dataWidth+inWidth-1:0] checksum
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [inWidth-1:0] LAST_ADDR = '1;

   state_t               state_q, state_d;
   logic [inWidth-1:0]   cnt_q, cnt_d;
   logic                 s_ready_q, s_ready_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 wr_en_q, wr_en_d;
   logic [inWidth-1:0]   wr_addr_q, wr_addr_d;
   logic [dataWidth-1:0] wr_data_q, wr_data_d;
   logic                 accept;
   logic                 load_begin;

   // An abort in LOAD takes priority over a simultaneous handshake.
   assign accept     = (state_q == LOAD) && s_valid && s_ready_q && !abort;
   assign load_begin = (state_q == IDLE) && start && !abort;

   // Next-state, counter and registered-output logic for the load sequence.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      case (state_q)
         IDLE: begin
            if (load_begin) begin
               state_d = LOAD;
               cnt_d   = '0;
            end
         end
         LOAD: begin
            if (abort) begin
               state_d = IDLE;
            end else if (accept) begin
               wr_en_d   = 1'b1;
               wr_addr_d = cnt_q;
               wr_data_d = s_data;
               cnt_d     = cnt_q + 1'b1;
               if (cnt_q == LAST_ADDR) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // The status flags are decoded from the next state so that they come
      // out of flops aligned with the state they describe.
      s_ready_d = (state_d == LOAD);
      busy_d    = (state_d == LOAD);
      done_d    = (state_d == DONE);
   end

   // State and output registers; reset returns everything to an idle, empty state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         s_ready_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         s_ready_q <= s_ready_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign s_ready     = s_ready_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign lut_wr_en   = wr_en_q;
   assign lut_wr_addr = wr_addr_q;
   assign lut_wr_data = wr_data_q;

`ifdef LUT_CHECKSUM_EN
   logic [dataWidth+inWidth-1:0] sum_q, sum_d;

   // Running sum of accepted words, restarted when a new load begins.
   always_comb begin
      sum_d = sum_q;
      if (load_begin) begin
         sum_d = '0;
      end else if (accept) begin
         sum_d = sum_q + {{inWidth{1'b0}}, s_data};
      end
   end

   // Checksum register.
   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign checksum = sum_q;
`endif

endmodule

// File: tb/tb_sigmoid_lut_loader.sv
// Testbench for sigmoid_lut_loader (inWidth=4, dataWidth=16).
// It holds a transaction-level model of the loader and compares the DUT
// against it on every cycle. It also checks a set of hand-computed results.
module tb_sigmoid_lut_loader;

   localparam int IW    = 4;
   localparam int DW    = 16;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          abort;
   logic [DW-1:0] s_data;
   logic          s_valid;
   logic          s_ready;
   logic          lut_wr_en;
   logic [IW-1:0] lut_wr_addr;
   logic [DW-1:0] lut_wr_data;
   logic          busy;
   logic          done;
`ifdef LUT_CHECKSUM_EN
   logic [DW+IW-1:0] checksum;
`endif

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   sigmoid_lut_loader #(.inWidth(IW), .dataWidth(DW)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .s_data     (s_data),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .lut_wr_en  (lut_wr_en),
      .lut_wr_addr(lut_wr_addr),
      .lut_wr_data(lut_wr_data),
      .busy       (busy),
      .done       (done)
`ifdef LUT_CHECKSUM_EN
      ,
      .checksum   (checksum)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act === want) passed++;
      else $display("FAIL %s: got %h, expected %h", name, act, want);
   endtask

   // ---------------- behavioural model ----------------
   // phase: 0 = waiting for start, 1 = loading, 2 = completion cycle
   int            m_phase = 0;
   int            m_idx   = 0;
   bit            m_init  = 1'b0;
   bit            e_wr    = 1'b0;
   logic [IW-1:0] e_addr  = '0;
   logic [DW-1:0] e_data  = '0;
`ifdef LUT_CHECKSUM_EN
   logic [DW+IW-1:0] m_sum = '0;
   logic [DW+IW-1:0] sum_at_done = '0;
`endif

   always @(posedge clk) begin
      m_init = 1'b1;
      e_wr   = 1'b0;
      if (rst) begin
         m_phase = 0;
         m_idx   = 0;
         e_addr  = '0;
         e_data  = '0;
`ifdef LUT_CHECKSUM_EN
         m_sum   = '0;
`endif
      end else if (m_phase == 0) begin
         if (start && !abort) begin
            m_phase = 1;
            m_idx   = 0;
`ifdef LUT_CHECKSUM_EN
            m_sum   = '0;
`endif
         end
      end else if (m_phase == 1) begin
         if (abort) begin
            m_phase = 0;
         end else if (s_valid) begin
            e_wr   = 1'b1;
            e_addr = m_idx[IW-1:0];
            e_data = s_data;
`ifdef LUT_CHECKSUM_EN
            m_sum  = m_sum + {4'h0, s_data};
`endif
            if (m_idx == DEPTH - 1) begin
               m_phase = 2;
               m_idx   = 0;
            end else begin
               m_idx++;
            end
         end
      end else begin
         m_phase = 0;
      end
   end

   // ---------------- per-cycle compare and write capture ----------------
   logic [DW-1:0] d_lut [DEPTH];
   int            wr_cnt    = 0;
   int            addr0_cnt = 0;
   int            done_cnt  = 0;
   logic [4:0]    done_tag  = '0;

   always @(negedge clk) begin
      if (m_init) begin
         check("cycle_outputs",
               {8'h00, s_ready, busy, done, lut_wr_en, lut_wr_addr, lut_wr_data},
               {8'h00, (m_phase == 1), (m_phase == 1), (m_phase == 2), e_wr, e_addr, e_data});
`ifdef LUT_CHECKSUM_EN
         check("checksum_cycle", {12'h000, checksum}, {12'h000, m_sum});
`endif
         if (lut_wr_en) begin
            d_lut[lut_wr_addr] = lut_wr_data;
            wr_cnt++;
            if (lut_wr_addr == '0) addr0_cnt++;
         end
         if (done) begin
            done_cnt++;
            done_tag = {lut_wr_en, lut_wr_addr};
`ifdef LUT_CHECKSUM_EN
            sum_at_done = checksum;
`endif
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle(input int n);
      s_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send(input logic [DW-1:0] w);
      int n = 0;
      s_valid = 1'b1;
      s_data  = w;
      while (!s_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("send_ready_timeout", {31'h0, s_ready}, 32'h1);
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   int base_wr, base_done, base_a0;

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b1; s_data = 16'hAAAA;
      for (int i = 0; i < DEPTH; i++) d_lut[i] = '0;

      // reset with s_valid held high
      repeat (3) @(negedge clk);
      #1;
      check("reset_outputs", {8'h00, s_ready, busy, done, lut_wr_en, lut_wr_addr, lut_wr_data}, 32'h0);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      check("no_write_before_start", wr_cnt, 0);
      check("ready_low_in_idle", {31'h0, s_ready}, 32'h0);

      // full back-to-back load
      base_wr = wr_cnt; base_done = done_cnt;
      pulse_start();
      for (int i = 0; i < DEPTH; i++) send(16'h0100 + 16'(i));
      idle(3);
      #1;
      check("full_write_count", wr_cnt - base_wr, 16);
      check("full_done_count", done_cnt - base_done, 1);
      check("done_with_addr15_write", {27'h0, done_tag}, 32'h1F);
      check("ready_low_after_done", {31'h0, s_ready}, 32'h0);
      for (int i = 0; i < DEPTH; i++) check("full_lut_entry", {16'h0, d_lut[i]}, 32'h0100 + 32'(i));

      // gapped load
      base_wr = wr_cnt; base_done = done_cnt;
      pulse_start();
      for (int i = 0; i < DEPTH; i++) begin
         send(16'h2000 + 16'(i));
         s_data = 16'hDEAD;
         idle(1);
      end
      idle(3);
      #1;
      check("gapped_write_count", wr_cnt - base_wr, 16);
      check("gapped_done_count", done_cnt - base_done, 1);
      check("gapped_entry9", {16'h0, d_lut[9]}, 32'h2009);

      // abort coincident with the 6th accept
      base_wr = wr_cnt; base_done = done_cnt;
      pulse_start();
      for (int i = 0; i < 5; i++) send(16'h3000 + 16'(i));
      s_valid = 1'b1; s_data = 16'h3005; abort = 1'b1;
      @(negedge clk);
      abort = 1'b0; s_valid = 1'b0;
      idle(3);
      #1;
      check("abort_write_count", wr_cnt - base_wr, 5);
      check("abort_no_done", done_cnt - base_done, 0);
      check("abort_busy_low", {31'h0, busy}, 32'h0);
      check("abort_entry4", {16'h0, d_lut[4]}, 32'h3004);
      check("abort_entry5_untouched", {16'h0, d_lut[5]}, 32'h2005);

      // abort together with start in IDLE: start ignored
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      idle(2);
      #1;
      check("abort_blocks_start", {31'h0, busy}, 32'h0);

      // reload after abort starts again at address 0
      base_wr = wr_cnt; base_done = done_cnt;
      pulse_start();
      for (int i = 0; i < DEPTH; i++) send(16'h4000 + 16'(i));
      idle(2);
      #1;
      check("reload_write_count", wr_cnt - base_wr, 16);
      check("reload_entry0", {16'h0, d_lut[0]}, 32'h4000);
      check("reload_done_count", done_cnt - base_done, 1);

      // start pulsed mid-load, then a 17th word offered
      base_wr = wr_cnt; base_a0 = addr0_cnt;
      pulse_start();
      for (int i = 0; i < 8; i++) send(16'h5000 + 16'(i));
      start = 1'b1;
      send(16'h5008);
      start = 1'b0;
      for (int i = 9; i < DEPTH; i++) send(16'h5000 + 16'(i));
      s_valid = 1'b1; s_data = 16'h5FFF;
      repeat (4) @(negedge clk);
      #1;
      check("extra_word_ready_low", {31'h0, s_ready}, 32'h0);
      s_valid = 1'b0;
      idle(2);
      #1;
      check("midstart_write_count", wr_cnt - base_wr, 16);
      check("midstart_addr0_once", addr0_cnt - base_a0, 1);
      check("midstart_entry0", {16'h0, d_lut[0]}, 32'h5000);
      check("midstart_entry8", {16'h0, d_lut[8]}, 32'h5008);

      // reset in the middle of a load drops the pending write
      base_wr = wr_cnt;
      pulse_start();
      for (int i = 0; i < 3; i++) send(16'h6000 + 16'(i));
      s_valid = 1'b1; s_data = 16'h6003; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; s_valid = 1'b0;
      idle(2);
      #1;
      check("rst_midload_writes", wr_cnt - base_wr, 3);
      check("rst_midload_busy", {31'h0, busy}, 32'h0);

`ifdef LUT_CHECKSUM_EN
      // checksum over a table of all-ones words
      pulse_start();
      for (int i = 0; i < DEPTH; i++) send(16'hFFFF);
      idle(2);
      #1;
      check("checksum_at_done", {12'h0, sum_at_done}, 32'h000FFFF0);
      check("checksum_held", {12'h0, checksum}, 32'h000FFFF0);
      pulse_start();
      #1;
      check("checksum_cleared", {12'h0, checksum}, 32'h0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      idle(2);
`endif

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, checks);
      $fatal(1);
   end

endmodule
